// File: rtl/fpu_add_subtract_sp_pkg.sv
// Shared constants and types for the single-precision add/sub unit.
// Holds field widths, bias, FSM state encoding and rounding-mode codes.
package fpu_add_pkg;

  localparam int EW   = 8;
  localparam int SW   = 23;
  localparam int BIAS = 127;
  localparam int DW   = SW + 5;

  localparam logic [1:0] RM_NEAR = 2'b00;
  localparam logic [1:0] RM_ZERO = 2'b01;
  localparam logic [1:0] RM_UP   = 2'b10;
  localparam logic [1:0] RM_DOWN = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_PACK,
    S_DONE
  } state_t;

endpackage

// File: rtl/fpu_add_subtract_sp_if.sv
// Host <-> add/sub unit bundle: start/abort, operands, mode and results.
// master = host sequencer, slave = the add/sub unit.
interface fpu_add_subtract_sp_if;
  import fpu_add_pkg::*;

  logic                beg_FSM;
  logic                rst_FSM;
  logic [EW+SW:0]      Data_X;
  logic [EW+SW:0]      Data_Y;
  logic                add_subt;
  logic [1:0]          r_mode;
  logic                overflow_flag;
  logic                underflow_flag;
  logic                ready;
  logic [EW+SW:0]      final_result_ieee;

  modport master (
    output beg_FSM, rst_FSM, Data_X, Data_Y,
    output add_subt, r_mode,
    input  overflow_flag, underflow_flag,
    input  ready, final_result_ieee
  );

  modport slave (
    input  beg_FSM, rst_FSM, Data_X, Data_Y,
    input  add_subt, r_mode,
    output overflow_flag, underflow_flag,
    output ready, final_result_ieee
  );

endinterface

// File: rtl/fpu_add_subtract_sp_lzd.sv
// Combinational leading-zero counter over the 28-bit add datapath.
// Ports: val (datapath word) -> cnt (zeros above the top set bit, 28 if none).
module fpu_lzd
  import fpu_add_pkg::*;
(
  input  logic [DW-1:0] val,
  output logic [4:0]    cnt
);

  always_comb begin
    cnt = 5'(DW);
    for (int i = 0; i < DW; i++) begin
      if (val[i]) cnt = 5'(DW - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_add_subtract_sp.sv
// Multi-cycle IEEE single add/sub: LOAD/ALIGN/ADD/NORM/ROUND/PACK/DONE.
// Ports: clk, rst (sync, high), bus (slave: start/abort, operands, results).
module fpu_add_subtract_sp
  import fpu_add_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  fpu_add_subtract_sp_if.slave bus
);

  state_t state, state_nx;

  logic [31:0]   x_q, y_q;
  logic          op_q;
  logic [1:0]    rm_q;

  logic          sign_a, sub_q;
  logic [7:0]    exp_a, exp_b;
  logic [23:0]   man_a, man_b;
  logic          spec_q, spec_ovf_q;
  logic [31:0]   spec_res_q;

  logic [DW-1:0] b_al, sum_q, norm_q;
  logic [9:0]    exp_n, exp_r;
  logic [22:0]   man_r;

  logic [31:0]   res_p;
  logic          ovf_p, unf_p;

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.rst_FSM) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (bus.beg_FSM) state_nx = S_LOAD;
        S_LOAD:  state_nx = S_ALIGN;
        S_ALIGN: state_nx = S_ADD;
        S_ADD:   state_nx = S_NORM;
        S_NORM:  state_nx = S_ROUND;
        S_ROUND: state_nx = S_PACK;
        S_PACK:  state_nx = S_DONE;
        S_DONE:  state_nx = S_DONE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // LOAD: effective signs, swap larger magnitude into A, classify
  logic        sx, sy, swap;
  logic        xz, yz, xi, yi;
  logic [31:0] a_w, b_w;
  logic        sa;
  logic        ld_spec, ld_ovf;
  logic [31:0] ld_res;

  always_comb begin
    sx   = x_q[31];
    sy   = y_q[31] ^ op_q;
    swap = y_q[30:0] > x_q[30:0];
    a_w  = swap ? y_q : x_q;
    b_w  = swap ? x_q : y_q;
    sa   = swap ? sy : sx;
    xz   = x_q[30:23] == 8'h00;
    yz   = y_q[30:23] == 8'h00;
    xi   = x_q[30:23] == 8'hff;
    yi   = y_q[30:23] == 8'hff;
    ld_spec = 1'b0;
    ld_ovf  = 1'b0;
    ld_res  = 32'h0;
    if (xi | yi) begin
      ld_spec = 1'b1;
      ld_ovf  = 1'b1;
      ld_res  = {sa, 8'hff, 23'h0};
    end else if (xz & yz) begin
      ld_spec = 1'b1;
      ld_res  = {sx & sy, 31'h0};
    end else if (xz | yz) begin
      // the nonzero operand always wins the swap
      ld_spec = 1'b1;
      ld_res  = {sa, a_w[30:0]};
    end else if (x_q[30:0] == y_q[30:0] && sx != sy) begin
      ld_spec = 1'b1;
      ld_res  = {rm_q == RM_DOWN, 31'h0};
    end
  end

  // ALIGN: right shift B with guard/round/sticky
  logic [7:0]    sh;
  logic [DW-1:0] b_ext, b_shr, b_mask, b_nx;

  always_comb begin
    sh     = exp_a - exp_b;
    b_ext  = {1'b0, man_b, 3'b000};
    b_shr  = b_ext >> sh;
    b_mask = (28'd1 << sh) - 28'd1;
    if (sh >= 8'd26) b_nx = 28'd1;
    else b_nx = {b_shr[DW-1:1], b_shr[0] | (|(b_ext & b_mask))};
  end

  // NORM: carry -> shift right, else left by (lz-1)
  logic [4:0]    lz;
  logic [4:0]    lsh;
  logic [DW-1:0] norm_nx;
  logic [9:0]    exp_nx;

  fpu_lzd u_lzd (
    .val (sum_q),
    .cnt (lz)
  );

  always_comb begin
    lsh = lz - 5'd1;
    if (sum_q[DW-1]) begin
      norm_nx = {1'b0, sum_q[DW-1:2], sum_q[1] | sum_q[0]};
      exp_nx  = {2'b00, exp_a} + 10'd1;
    end else begin
      norm_nx = sum_q << lsh;
      exp_nx  = {2'b00, exp_a} - {5'b0, lsh};
    end
  end

  // ROUND
  logic        g, r, s, lsb, inc;
  logic [24:0] rnd;

  always_comb begin
    g   = norm_q[2];
    r   = norm_q[1];
    s   = norm_q[0];
    lsb = norm_q[3];
    inc = 1'b0;
    unique case (rm_q)
      RM_NEAR: inc = g & (r | s | lsb);
      RM_ZERO: inc = 1'b0;
      RM_UP:   inc = (g | r | s) & ~sign_a;
      RM_DOWN: inc = (g | r | s) & sign_a;
      default: inc = 1'b0;
    endcase
    rnd = {1'b0, norm_q[26:3]} + {24'h0, inc};
  end

  // PACK
  logic [31:0] pk_res;
  logic        pk_ovf, pk_unf;

  always_comb begin
    pk_ovf = 1'b0;
    pk_unf = 1'b0;
    pk_res = {sign_a, exp_r[7:0], man_r};
    if (spec_q) begin
      pk_res = spec_res_q;
      pk_ovf = spec_ovf_q;
    end else if ($signed(exp_r) >= 10'sd255) begin
      pk_res = {sign_a, 8'hff, 23'h0};
      pk_ovf = 1'b1;
    end else if ($signed(exp_r) <= 10'sd0) begin
      pk_res = {sign_a, 31'h0};
      pk_unf = 1'b1;
    end
  end

  // datapath registers, each stage loads in its own state
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0; y_q <= '0; op_q <= 1'b0; rm_q <= '0;
      sign_a <= 1'b0; sub_q <= 1'b0;
      exp_a <= '0; exp_b <= '0; man_a <= '0; man_b <= '0;
      spec_q <= 1'b0; spec_ovf_q <= 1'b0; spec_res_q <= '0;
      b_al <= '0; sum_q <= '0; norm_q <= '0;
      exp_n <= '0; exp_r <= '0; man_r <= '0;
      res_p <= '0; ovf_p <= 1'b0; unf_p <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (bus.beg_FSM && !bus.rst_FSM) begin
          x_q  <= bus.Data_X;
          y_q  <= bus.Data_Y;
          op_q <= bus.add_subt;
          rm_q <= bus.r_mode;
        end
        S_LOAD: begin
          sign_a     <= sa;
          sub_q      <= sx ^ sy;
          exp_a      <= a_w[30:23];
          exp_b      <= b_w[30:23];
          man_a      <= {1'b1, a_w[22:0]};
          man_b      <= {1'b1, b_w[22:0]};
          spec_q     <= ld_spec;
          spec_ovf_q <= ld_ovf;
          spec_res_q <= ld_res;
        end
        S_ALIGN: b_al <= b_nx;
        S_ADD: begin
          if (sub_q) sum_q <= {1'b0, man_a, 3'b000} - b_al;
          else       sum_q <= {1'b0, man_a, 3'b000} + b_al;
        end
        S_NORM: begin
          norm_q <= norm_nx;
          exp_n  <= exp_nx;
        end
        S_ROUND: begin
          exp_r <= rnd[24] ? exp_n + 10'd1 : exp_n;
          man_r <= rnd[24] ? rnd[23:1] : rnd[22:0];
        end
        S_PACK: begin
          res_p <= pk_res;
          ovf_p <= pk_ovf;
          unf_p <= pk_unf;
        end
        default: ;
      endcase
    end
  end

  // outputs register one edge after DONE is entered
  always_ff @(posedge clk) begin
    if (rst || bus.rst_FSM) begin
      bus.ready             <= 1'b0;
      bus.final_result_ieee <= '0;
      bus.overflow_flag     <= 1'b0;
      bus.underflow_flag    <= 1'b0;
    end else if (state == S_DONE) begin
      bus.ready             <= 1'b1;
      bus.final_result_ieee <= res_p;
      bus.overflow_flag     <= ovf_p;
      bus.underflow_flag    <= unf_p;
    end
  end

endmodule

// File: tb/tb_fpu_add_subtract_sp.sv
// Directed self-checking bench for fpu_add_subtract_sp.
// Each task drives one scenario and compares against hand-computed values.
module tb_fpu_add_subtract_sp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fpu_add_subtract_sp_if bus();

  fpu_add_subtract_sp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic op, input logic [1:0] rm,
                        output int lat);
    @(posedge clk); #1;
    bus.Data_X = x; bus.Data_Y = y;
    bus.add_subt = op; bus.r_mode = rm;
    bus.beg_FSM = 1'b1;
    @(posedge clk); #1;
    bus.beg_FSM = 1'b0;
    bus.Data_X = 32'hdeadbeef; bus.Data_Y = 32'h12345678;
    bus.add_subt = ~op; bus.r_mode = ~rm;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.ready) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic clear_op();
    bus.rst_FSM = 1'b1;
    @(posedge clk); #1;
    bus.rst_FSM = 1'b0;
  endtask

  task automatic test_reset();
    bus.beg_FSM = 1'b0; bus.rst_FSM = 1'b0;
    bus.Data_X = '0; bus.Data_Y = '0;
    bus.add_subt = 1'b0; bus.r_mode = 2'b00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b want 0", bus.ready);
    end
    checks++;
    if (bus.final_result_ieee !== 32'h0) begin
      errors++;
      $display("FAIL reset_result got %h want 0", bus.final_result_ieee);
    end
    checks++;
    if ({bus.overflow_flag, bus.underflow_flag} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags got %b%b want 00",
               bus.overflow_flag, bus.underflow_flag);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_add();
    int lat;
    run_op(32'h3F800000, 32'h40000000, 1'b0, 2'b00, lat);
    checks++;
    if (lat !== 7) begin
      errors++; $display("FAIL add_latency got %0d want 7", lat);
    end
    checks++;
    if (bus.final_result_ieee !== 32'h40400000) begin
      errors++;
      $display("FAIL add_result got %h want 40400000",
               bus.final_result_ieee);
    end
    checks++;
    if ({bus.overflow_flag, bus.underflow_flag} !== 2'b00) begin
      errors++; $display("FAIL add_flags got %b%b want 00",
                         bus.overflow_flag, bus.underflow_flag);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b1 || bus.final_result_ieee !== 32'h40400000) begin
      errors++; $display("FAIL add_hold got %b/%h want 1/40400000",
                         bus.ready, bus.final_result_ieee);
    end
    clear_op();
    checks++;
    if (bus.ready !== 1'b0 || bus.final_result_ieee !== 32'h0) begin
      errors++; $display("FAIL add_clear got %b/%h want 0/00000000",
                         bus.ready, bus.final_result_ieee);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] vx [9] = '{32'h3F800000, 32'h3F800000, 32'h00000000,
                            32'h40A00000, 32'h40400000, 32'h3F800000,
                            32'h3F800000, 32'h3F800000, 32'h3F800001};
    logic [31:0] vy [9] = '{32'h3F800000, 32'h3F800000, 32'hC1200000,
                            32'h00000000, 32'h3F800000, 32'h33800000,
                            32'h33800000, 32'h33800000, 32'h33800000};
    logic        vo [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                            1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0]  vm [9] = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00,
                            2'b00, 2'b10, 2'b01, 2'b00};
    logic [31:0] ve [9] = '{32'h00000000, 32'h80000000, 32'hC1200000,
                            32'h40A00000, 32'h40000000, 32'h3F800000,
                            32'h3F800001, 32'h3F800000, 32'h3F800002};
    int lat;
    for (int i = 0; i < 9; i++) begin
      run_op(vx[i], vy[i], vo[i], vm[i], lat);
      checks++;
      if (lat == 0 || bus.final_result_ieee !== ve[i]) begin
        errors++;
        $display("FAIL vec%0d got %h (lat %0d) want %h",
                 i, bus.final_result_ieee, lat, ve[i]);
      end
      checks++;
      if ({bus.overflow_flag, bus.underflow_flag} !== 2'b00) begin
        errors++; $display("FAIL vec%0d_flags got %b%b want 00", i,
                           bus.overflow_flag, bus.underflow_flag);
      end
      clear_op();
    end
  endtask

  task automatic test_overflow_underflow();
    int lat;
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b01, lat);
    checks++;
    if (lat == 0 || bus.final_result_ieee !== 32'h7F800000) begin
      errors++; $display("FAIL ovf_result got %h want 7f800000",
                         bus.final_result_ieee);
    end
    checks++;
    if ({bus.overflow_flag, bus.underflow_flag} !== 2'b10) begin
      errors++; $display("FAIL ovf_flags got %b%b want 10",
                         bus.overflow_flag, bus.underflow_flag);
    end
    clear_op();
    run_op(32'h00800001, 32'h00800000, 1'b1, 2'b00, lat);
    checks++;
    if (lat == 0 || bus.final_result_ieee !== 32'h00000000) begin
      errors++; $display("FAIL unf_result got %h want 00000000",
                         bus.final_result_ieee);
    end
    checks++;
    if ({bus.overflow_flag, bus.underflow_flag} !== 2'b01) begin
      errors++; $display("FAIL unf_flags got %b%b want 01",
                         bus.overflow_flag, bus.underflow_flag);
    end
    clear_op();
  endtask

  task automatic test_abort();
    @(posedge clk); #1;
    bus.Data_X = 32'h3F800000; bus.Data_Y = 32'h40000000;
    bus.add_subt = 1'b0; bus.r_mode = 2'b00;
    bus.beg_FSM = 1'b1;
    @(posedge clk); #1;
    bus.beg_FSM = 1'b0;
    @(posedge clk); #1;
    bus.rst_FSM = 1'b1;
    @(posedge clk); #1;
    bus.rst_FSM = 1'b0;
    begin
      logic seen = 1'b0;
      for (int n = 0; n < 12; n++) begin
        @(posedge clk); #1;
        if (bus.ready) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
        errors++; $display("FAIL abort_align ready got 1 want 0");
      end
    end
  endtask

  task automatic test_ignore_starts();
    int lat;
    logic seen;
    @(posedge clk); #1;
    bus.Data_X = 32'h40400000; bus.Data_Y = 32'h3F800000;
    bus.add_subt = 1'b1; bus.r_mode = 2'b00;
    bus.beg_FSM = 1'b1;
    @(posedge clk); #1;
    bus.beg_FSM = 1'b0;
    @(posedge clk); #1;
    bus.Data_X = 32'h7F7FFFFF; bus.Data_Y = 32'h7F7FFFFF;
    bus.add_subt = 1'b0; bus.beg_FSM = 1'b1;
    @(posedge clk); #1;
    bus.beg_FSM = 1'b0;
    lat = 0;
    for (int n = 3; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.ready) begin lat = n; break; end
    end
    checks++;
    if (lat !== 7 || bus.final_result_ieee !== 32'h40000000) begin
      errors++; $display("FAIL busy_start got %h lat %0d want 40000000 lat 7",
                         bus.final_result_ieee, lat);
    end
    clear_op();
    bus.beg_FSM = 1'b1; bus.rst_FSM = 1'b1;
    @(posedge clk); #1;
    bus.beg_FSM = 1'b0; bus.rst_FSM = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (bus.ready) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL beg_with_rst ready got 1 want 0");
    end
    run_op(32'h40000000, 32'hBF800000, 1'b1, 2'b00, lat);
    checks++;
    if (lat !== 7 || bus.final_result_ieee !== 32'h40400000) begin
      errors++; $display("FAIL fresh_start got %h lat %0d want 40400000 lat 7",
                         bus.final_result_ieee, lat);
    end
    clear_op();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_vectors();
    test_overflow_underflow();
    test_abort();
    test_ignore_starts();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
